// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg
//   Shared constants and helpers for the multi-stage pipeline register.
//   BUBBLE_DATA : payload value that a bubble (invalid stage) carries (MIPS NOP = 0)
//   MAX_DEPTH   : largest supported number of stages
//   PERF_CNT_W  : width of the optional performance counters (PIPE_REG_PERF_EN)
//   satInc()    : saturating increment used by the performance counters
package pipe_reg_pkg;

  localparam int BUBBLE_DATA = 0;
  localparam int MAX_DEPTH   = 8;
  localparam int PERF_CNT_W  = 32;

  // Counters stick at all-ones instead of wrapping back to zero
  function automatic logic [PERF_CNT_W-1:0] satInc(input logic [PERF_CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_reg_if.sv
// pipe_reg_if
//   Bundles the payload, control and status signals of pipe_reg.
//   Parameters: N (payload width), DEPTH (number of stages).
//   in_valid/in        : payload entering stage 0
//   stall/flush        : per-stage hold request / bubble request from the hazard unit
//   out/out_valid      : contents of the last stage
//   stage_valid/hold   : valid bit and effective hold of every stage
//   perf_stall_cnt/perf_bubble_cnt : only present when PIPE_REG_PERF_EN is defined
//   Modports: master (hazard unit / surrounding datapath), slave (pipe_reg).
interface pipe_reg_if
  import pipe_reg_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 1
);

  logic             in_valid;
  logic [N-1:0]     in;
  logic [DEPTH-1:0] stall;
  logic [DEPTH-1:0] flush;
  logic [N-1:0]     out;
  logic             out_valid;
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] hold;
`ifdef PIPE_REG_PERF_EN
  logic [PERF_CNT_W-1:0] perf_stall_cnt;
  logic [PERF_CNT_W-1:0] perf_bubble_cnt;
`endif

  modport master (
    output in_valid, in, stall, flush,
    input  out, out_valid, stage_valid, hold
`ifdef PIPE_REG_PERF_EN
    , input perf_stall_cnt, perf_bubble_cnt
`endif
  );

  modport slave (
    input  in_valid, in, stall, flush,
    output out, out_valid, stage_valid, hold
`ifdef PIPE_REG_PERF_EN
    , output perf_stall_cnt, perf_bubble_cnt
`endif
  );

endinterface

// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage
//   One pipeline stage: an N-bit payload flop plus its valid bit.
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   i_flush     : turn this stage into a bubble at the next edge (beats hold)
//   i_hold      : keep current contents
//   i_upHold    : the upstream stage is holding, so nothing new arrives -> bubble
//   i_data/i_valid : contents offered by the upstream stage (or the pipe input)
//   o_data/o_valid : current contents of this stage
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_hold,
  input  logic         i_upHold,
  input  logic [N-1:0] i_data,
  input  logic         i_valid,
  output logic [N-1:0] o_data,
  output logic         o_valid
);

  logic [N-1:0] r_data;
  logic         r_valid;

  // Flush wins over hold so a held stage can still be squashed; a held
  // upstream stage means its contents stay there, so a bubble is shifted in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= N'(BUBBLE_DATA);
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_data  <= N'(BUBBLE_DATA);
      r_valid <= 1'b0;
    end else if (i_hold) begin
      r_data  <= r_data;
      r_valid <= r_valid;
    end else if (i_upHold) begin
      r_data  <= N'(BUBBLE_DATA);
      r_valid <= 1'b0;
    end else begin
      r_data  <= i_data;
      r_valid <= i_valid;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/pipe_reg.sv
// pipe_reg
//   Parametrised multi-stage pipeline register (payload + valid) with
//   per-stage stall and flush, for use between CPU pipeline stages.
//   Parameters: N (payload width, >=1), DEPTH (stages, 1..MAX_DEPTH).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pipe_reg_if.slave carrying in/in_valid/stall/flush and
//           out/out_valid/stage_valid/hold
//   Optional macro PIPE_REG_PERF_EN adds perf_stall_cnt and perf_bubble_cnt
//   to the interface and the saturating counters that drive them.
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_reg_if.slave  bus
);

  logic [DEPTH:0]   w_holdExt;
  logic [N-1:0]     w_stageData [DEPTH];
  logic [DEPTH-1:0] w_stageValid;

  // A stall anywhere downstream forces every stage above it to hold too,
  // otherwise the upstream stage would overwrite data that cannot move on.
  // The extra top bit is a constant 0 that terminates the chain.
  always_comb begin
    w_holdExt = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_holdExt[i] = bus.stall[i] | w_holdExt[i+1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gStage
    logic [N-1:0] w_upData;
    logic         w_upValid;
    logic         w_upHold;

    if (g == 0) begin : gFirst
      assign w_upData  = bus.in;
      assign w_upValid = bus.in_valid;
      assign w_upHold  = 1'b0;
    end else begin : gRest
      assign w_upData  = w_stageData[g-1];
      assign w_upValid = w_stageValid[g-1];
      assign w_upHold  = w_holdExt[g-1];
    end

    pipe_reg_stage #(.N(N)) uStage (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_flush  (bus.flush[g]),
      .i_hold   (w_holdExt[g]),
      .i_upHold (w_upHold),
      .i_data   (w_upData),
      .i_valid  (w_upValid),
      .o_data   (w_stageData[g]),
      .o_valid  (w_stageValid[g])
    );
  end

  assign bus.out         = w_stageData[DEPTH-1];
  assign bus.out_valid   = w_stageValid[DEPTH-1];
  assign bus.stage_valid = w_stageValid;
  assign bus.hold        = w_holdExt[DEPTH-1:0];

`ifdef PIPE_REG_PERF_EN
  logic [PERF_CNT_W-1:0] r_perfStallCnt;
  logic [PERF_CNT_W-1:0] r_perfBubbleCnt;

  // Stall cycles are seen at the pipe entry (hold[0]); bubble cycles are
  // cycles in which the last stage presents nothing valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perfStallCnt  <= '0;
      r_perfBubbleCnt <= '0;
    end else begin
      if (w_holdExt[0]) begin
        r_perfStallCnt <= satInc(r_perfStallCnt);
      end
      if (!w_stageValid[DEPTH-1]) begin
        r_perfBubbleCnt <= satInc(r_perfBubbleCnt);
      end
    end
  end

  assign bus.perf_stall_cnt  = r_perfStallCnt;
  assign bus.perf_bubble_cnt = r_perfBubbleCnt;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg
//   Directed, table-driven bench for pipe_reg (N=8, DEPTH=3), plus
//   hand-written sequences for asynchronous reset and, when
//   PIPE_REG_PERF_EN is defined, the performance counters (DEPTH=2).
module tb_pipe_reg;
  import pipe_reg_pkg::*;

  localparam int N       = 8;
  localparam int DEPTH   = 3;
  localparam int NUM_VEC = 21;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  // Free-running 10-time-unit clock
  always #5 clk = ~clk;

  pipe_reg_if #(.N(N), .DEPTH(DEPTH)) bus ();

  pipe_reg #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef PIPE_REG_PERF_EN
  logic perfRst_n = 1'b0;

  pipe_reg_if #(.N(N), .DEPTH(2)) perfBus ();

  pipe_reg #(.N(N), .DEPTH(2)) perfDut (
    .clk   (clk),
    .rst_n (perfRst_n),
    .bus   (perfBus)
  );
`endif

  // One cycle of stimulus and the state expected after the following edge
  typedef struct {
    logic             inValid;
    logic [N-1:0]     inData;
    logic [DEPTH-1:0] stall;
    logic [DEPTH-1:0] flush;
    logic [N-1:0]     expOut;
    logic             expOutValid;
    logic [DEPTH-1:0] expStageValid;
    logic [DEPTH-1:0] expHold;
  } vecRecord_t;

  vecRecord_t vecs [NUM_VEC];

  // Compare one value and report a mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one record at the falling edge, check the combinational hold,
  // then check the registered outputs just after the rising edge
  task automatic applyStimulus(input vecRecord_t v, input string tag);
    @(negedge clk);
    bus.in_valid = v.inValid;
    bus.in       = v.inData;
    bus.stall    = v.stall;
    bus.flush    = v.flush;
    #1;
    checkOutput({tag, " hold"}, 32'(bus.hold), 32'(v.expHold));
    @(posedge clk);
    #1;
    checkOutput({tag, " out"},         32'(bus.out),         32'(v.expOut));
    checkOutput({tag, " out_valid"},   32'(bus.out_valid),   32'(v.expOutValid));
    checkOutput({tag, " stage_valid"}, 32'(bus.stage_valid), 32'(v.expStageValid));
  endtask

  // Main test sequence
  initial begin
    vecRecord_t r;

    bus.in_valid = 1'b0;
    bus.in       = '0;
    bus.stall    = '0;
    bus.flush    = '0;
`ifdef PIPE_REG_PERF_EN
    perfBus.in_valid = 1'b0;
    perfBus.in       = '0;
    perfBus.stall    = '0;
    perfBus.flush    = '0;
`endif

    //            inV   in     stall   flush  | out    oV    stgV    hold
    vecs[0]  = '{1'b1, 8'h11, 3'b000, 3'b000, 8'h00, 1'b0, 3'b001, 3'b000};
    vecs[1]  = '{1'b1, 8'h22, 3'b000, 3'b000, 8'h00, 1'b0, 3'b011, 3'b000};
    vecs[2]  = '{1'b1, 8'h33, 3'b000, 3'b000, 8'h11, 1'b1, 3'b111, 3'b000};
    vecs[3]  = '{1'b1, 8'h44, 3'b000, 3'b000, 8'h22, 1'b1, 3'b111, 3'b000};
    vecs[4]  = '{1'b1, 8'h55, 3'b000, 3'b000, 8'h33, 1'b1, 3'b111, 3'b000};
    vecs[5]  = '{1'b1, 8'h66, 3'b100, 3'b000, 8'h33, 1'b1, 3'b111, 3'b111};
    vecs[6]  = '{1'b1, 8'h66, 3'b100, 3'b000, 8'h33, 1'b1, 3'b111, 3'b111};
    vecs[7]  = '{1'b1, 8'h66, 3'b000, 3'b000, 8'h44, 1'b1, 3'b111, 3'b000};
    vecs[8]  = '{1'b1, 8'h77, 3'b001, 3'b000, 8'h55, 1'b1, 3'b101, 3'b001};
    vecs[9]  = '{1'b1, 8'h77, 3'b000, 3'b000, 8'h00, 1'b0, 3'b011, 3'b000};
    vecs[10] = '{1'b1, 8'h88, 3'b000, 3'b000, 8'h66, 1'b1, 3'b111, 3'b000};
    vecs[11] = '{1'b1, 8'h99, 3'b111, 3'b011, 8'h66, 1'b1, 3'b100, 3'b111};
    vecs[12] = '{1'b1, 8'hAA, 3'b111, 3'b000, 8'h66, 1'b1, 3'b100, 3'b111};
    vecs[13] = '{1'b1, 8'hAA, 3'b000, 3'b000, 8'h00, 1'b0, 3'b001, 3'b000};
    vecs[14] = '{1'b0, 8'hBB, 3'b000, 3'b000, 8'h00, 1'b0, 3'b010, 3'b000};
    vecs[15] = '{1'b1, 8'hCC, 3'b000, 3'b000, 8'hAA, 1'b1, 3'b101, 3'b000};
    vecs[16] = '{1'b1, 8'hDD, 3'b000, 3'b000, 8'hBB, 1'b0, 3'b011, 3'b000};
    vecs[17] = '{1'b1, 8'hEE, 3'b010, 3'b100, 8'h00, 1'b0, 3'b011, 3'b011};
    vecs[18] = '{1'b1, 8'hEE, 3'b000, 3'b001, 8'hCC, 1'b1, 3'b110, 3'b000};
    vecs[19] = '{1'b1, 8'hFF, 3'b000, 3'b000, 8'hDD, 1'b1, 3'b101, 3'b000};
    vecs[20] = '{1'b1, 8'h01, 3'b000, 3'b010, 8'h00, 1'b0, 3'b001, 3'b000};

    // Reset state while rst_n is held low
    #3;
    checkOutput("reset out",         32'(bus.out),         32'h0);
    checkOutput("reset out_valid",   32'(bus.out_valid),   32'h0);
    checkOutput("reset stage_valid", 32'(bus.stage_valid), 32'h0);
    checkOutput("reset hold",        32'(bus.hold),        32'h0);
`ifdef PIPE_REG_PERF_EN
    checkOutput("reset perf_stall_cnt",  perfBus.perf_stall_cnt,  32'h0);
    checkOutput("reset perf_bubble_cnt", perfBus.perf_bubble_cnt, 32'h0);
`endif

    @(negedge clk);
    rst_n = 1'b1;

    // Table: fill, stall at the tail, stall at the head, flush under stall,
    // invalid payloads, and flush combined with a partial stall
    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Refill partially, then assert reset asynchronously between edges
    r = '{1'b1, 8'h21, 3'b000, 3'b000, 8'h00, 1'b0, 3'b011, 3'b000};
    applyStimulus(r, "pre-reset 0");
    r = '{1'b1, 8'h22, 3'b000, 3'b000, 8'h01, 1'b1, 3'b111, 3'b000};
    applyStimulus(r, "pre-reset 1");

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out",         32'(bus.out),         32'h0);
    checkOutput("async reset out_valid",   32'(bus.out_valid),   32'h0);
    checkOutput("async reset stage_valid", 32'(bus.stage_valid), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("in reset stage_valid", 32'(bus.stage_valid), 32'h0);

    // Release with an idle input, then refill from empty
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in       = '0;
    #2;
    rst_n = 1'b1;

    r = '{1'b1, 8'h31, 3'b000, 3'b000, 8'h00, 1'b0, 3'b001, 3'b000};
    applyStimulus(r, "refill 0");
    r = '{1'b1, 8'h32, 3'b000, 3'b000, 8'h00, 1'b0, 3'b011, 3'b000};
    applyStimulus(r, "refill 1");
    r = '{1'b1, 8'h33, 3'b000, 3'b000, 8'h31, 1'b1, 3'b111, 3'b000};
    applyStimulus(r, "refill 2");
    r = '{1'b1, 8'h34, 3'b000, 3'b000, 8'h32, 1'b1, 3'b111, 3'b000};
    applyStimulus(r, "refill 3");

`ifdef PIPE_REG_PERF_EN
    // Two-stage pipe: two empty cycles while filling, then 5 tail stalls
    @(negedge clk);
    perfBus.in_valid = 1'b1;
    perfBus.in       = 8'h5A;
    perfBus.stall    = 2'b00;
    #2;
    perfRst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("perf fill out_valid",       32'(perfBus.out_valid),  32'h1);
    checkOutput("perf fill perf_bubble_cnt", perfBus.perf_bubble_cnt, 32'h2);
    checkOutput("perf fill perf_stall_cnt",  perfBus.perf_stall_cnt,  32'h0);

    @(negedge clk);
    perfBus.stall = 2'b10;
    repeat (5) @(posedge clk);
    @(negedge clk);
    perfBus.stall = 2'b00;
    #1;
    checkOutput("perf stall perf_stall_cnt",  perfBus.perf_stall_cnt,  32'h5);
    checkOutput("perf stall perf_bubble_cnt", perfBus.perf_bubble_cnt, 32'h2);
    @(posedge clk);
    #1;
    checkOutput("perf release perf_stall_cnt", perfBus.perf_stall_cnt, 32'h5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
